// File: rtl/alu_seq_pkg.sv
// Shared types for the alu4bit nibble sequencer: command ops, alu4bit OP
// encodings and the sequencer state.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        CMD_ADD = 2'b00,
        CMD_SUB = 2'b01,
        CMD_AND = 2'b10,
        CMD_OR  = 2'b11
    } cmd_op_e;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_AND = 2'b10;
    localparam logic [1:0] ALU_OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

    // SUB rides the ADD datapath as A + ~B + carry; alu4bit's own SUB
    // encoding produces a borrow that cannot be chained across nibbles.
    function automatic logic [1:0] alu_op_of(input cmd_op_e op);
        case (op)
            CMD_AND: alu_op_of = ALU_OP_AND;
            CMD_OR:  alu_op_of = ALU_OP_OR;
            default: alu_op_of = ALU_OP_ADD;
        endcase
    endfunction

    function automatic logic is_arith(input cmd_op_e op);
        is_arith = (op == CMD_ADD) || (op == CMD_SUB);
    endfunction

endpackage

// File: rtl/alu4bit_nibble_seq.sv
// Feeds a wide ADD/SUB/AND/OR command through a 4-bit alu4bit one nibble per
// cycle, chaining the carry and assembling a wide result with flags.
module alu4bit_nibble_seq
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_cin,
    input  logic         cmd_binv,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic         alu_cin,
    output logic         alu_binv,
    output logic [1:0]   alu_op,
    input  logic [3:0]   alu_y,
    input  logic         alu_cout,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_cout,
    output logic         res_zero,
    output logic         res_ovf
);

    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    seq_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    cmd_op_e        op_q, op_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic           alu_cin_q, alu_cin_d, alu_binv_q, alu_binv_d;
    logic [1:0]     alu_op_q, alu_op_d;
    logic [W-1:0]   res_q, res_d;
    logic           res_valid_q, res_valid_d;
    logic           res_cout_q, res_cout_d;
    logic           res_zero_q, res_zero_d;
    logic           res_ovf_q, res_ovf_d;
    cmd_op_e        cmd_op_e_w;
    logic           beff_msb;

    assign cmd_op_e_w = cmd_op_e'(cmd_op);
    assign beff_msb   = (op_q == CMD_SUB) ? ~b_q[W-1] : b_q[W-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_binv_d  = alu_binv_q;
        alu_op_d    = alu_op_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        res_cout_d  = res_cout_q;
        res_zero_d  = res_zero_q;
        res_ovf_d   = res_ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    op_d       = cmd_op_e_w;
                    a_d        = cmd_a;
                    b_d        = cmd_b;
                    alu_a_d    = cmd_a[3:0];
                    alu_b_d    = cmd_b[3:0];
                    alu_op_d   = alu_op_of(cmd_op_e_w);
                    case (cmd_op_e_w)
                        CMD_ADD: begin alu_binv_d = 1'b0;     alu_cin_d = cmd_cin;  end
                        CMD_SUB: begin alu_binv_d = 1'b1;     alu_cin_d = ~cmd_cin; end
                        default: begin alu_binv_d = cmd_binv; alu_cin_d = 1'b0;     end
                    endcase
                end
            end
            ST_RUN: begin
                res_d[{cnt_q, 2'b00} +: 4] = alu_y;
                if (cnt_q == LAST) begin
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                    alu_a_d     = '0;
                    alu_b_d     = '0;
                    alu_cin_d   = 1'b0;
                    alu_binv_d  = 1'b0;
                    alu_op_d    = '0;
                    res_cout_d  = is_arith(op_q) & alu_cout;
                    res_zero_d  = (res_d == '0);
                    res_ovf_d   = is_arith(op_q) && (a_q[W-1] == beff_msb)
                                  && (res_d[W-1] != a_q[W-1]);
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    alu_a_d   = a_q[{cnt_d, 2'b00} +: 4];
                    alu_b_d   = b_q[{cnt_d, 2'b00} +: 4];
                    alu_cin_d = is_arith(op_q) & alu_cout;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= CMD_ADD;
            a_q         <= '0;
            b_q         <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_binv_q  <= 1'b0;
            alu_op_q    <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            res_cout_q  <= 1'b0;
            res_zero_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_binv_q  <= alu_binv_d;
            alu_op_q    <= alu_op_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            res_cout_q  <= res_cout_d;
            res_zero_q  <= res_zero_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    // Held low through reset so no command can slip in while it is asserted.
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign alu_binv  = alu_binv_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_q;
    assign res_cout  = res_cout_q;
    assign res_zero  = res_zero_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_alu4bit_nibble_seq.sv
// Randomized and directed bench for alu4bit_nibble_seq with a behavioural
// alu4bit beside it and an arithmetic reference model.
module tb_alu4bit_nibble_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0, cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_a = '0, cmd_b = '0;
    logic         cmd_cin = 1'b0, cmd_binv = 1'b0;
    logic [3:0]   alu_a, alu_b, alu_y;
    logic         alu_cin, alu_binv, alu_cout;
    logic [1:0]   alu_op;
    logic         res_valid, res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_cout, res_zero, res_ovf;

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] last_res;
    logic         last_cout, last_zero, last_ovf;
    int           last_lat;

    always #5 clk = ~clk;

    alu4bit_nibble_seq #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_binv(cmd_binv),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_binv(alu_binv),
        .alu_op(alu_op), .alu_y(alu_y), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_zero(res_zero), .res_ovf(res_ovf)
    );

    // Behavioural alu4bit; the 01 encoding is never expected from the DUT.
    logic [3:0] bb;
    logic [4:0] sum5;
    always_comb begin
        bb   = alu_binv ? ~alu_b : alu_b;
        sum5 = {1'b0, alu_a} + {1'b0, bb} + {4'b0, alu_cin};
        case (alu_op)
            2'b00:   begin alu_y = sum5[3:0];   alu_cout = sum5[4]; end
            2'b10:   begin alu_y = alu_a & bb;  alu_cout = 1'b0;    end
            2'b11:   begin alu_y = alu_a | bb;  alu_cout = 1'b0;    end
            default: begin alu_y = 4'h0;        alu_cout = 1'b0;    end
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint sval(input logic [W-1:0] v);
        sval = v[W-1] ? longint'(v) - (longint'(1) << W) : longint'(v);
    endfunction

    // Reference result from plain integer arithmetic on the whole words.
    task automatic ref_model(input logic [1:0] op, input logic [W-1:0] a, b,
                             input logic cin, binv,
                             output logic [W-1:0] r, output logic c, z, v);
        longint u, s;
        logic [W-1:0] be;
        u = 0; s = 0; c = 0; v = 0;
        be = binv ? ~b : b;
        case (op)
            2'b00: begin
                u = longint'(a) + longint'(b) + longint'(cin);
                s = sval(a) + sval(b) + longint'(cin);
                c = (u >= (longint'(1) << W));
            end
            2'b01: begin
                u = longint'(a) - longint'(b) - longint'(cin);
                s = sval(a) - sval(b) - longint'(cin);
                c = (u >= 0);
            end
            2'b10: u = longint'(a & be);
            default: u = longint'(a | be);
        endcase
        r = u[W-1:0];
        if (op[1] == 1'b0)
            v = (s > (longint'(1) << (W - 1)) - 1) || (s < -(longint'(1) << (W - 1)));
        z = (r == '0);
    endtask

    // Carry that should enter nibble k: carry out of the low 4k bits.
    function automatic logic carry_in(input logic [1:0] op, input logic [W-1:0] a, b,
                                      input logic cin, input int k);
        longint m, t;
        if (op[1]) return 1'b0;
        if (k == 0) return (op == 2'b01) ? ~cin : cin;
        m = (longint'(1) << (4 * k)) - 1;
        if (op == 2'b00) t = (longint'(a) & m) + (longint'(b) & m) + longint'(cin);
        else             t = (longint'(a) & m) + (longint'(~b) & m) + longint'(~cin);
        return t[4*k];
    endfunction

    task automatic wait_ready();
        int budget = 50;
        while (!cmd_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!cmd_ready) begin
            $display("FAIL wait_ready: cmd_ready stuck low, expected 1");
            n_err++;
            $display("Result: errors=%0d of %0d checks", n_err, n_chk);
            $fatal(1, "timeout");
        end
    endtask

    // One command end to end. During backpressure, optionally offer the
    // next command (np/na/nb/...) to show it is only taken after handshake.
    task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] a, b,
                          input logic cin, binv, input int hold, input bit preload,
                          input logic [1:0] np, input logic [W-1:0] na, nb,
                          input logic ncin, nbinv);
        logic [W-1:0] er;
        logic ec, ez, ev, eb;
        int lat;
        ref_model(op, a, b, cin, binv, er, ec, ez, ev);
        eb = (op == 2'b01) ? 1'b1 : (op == 2'b00) ? 1'b0 : binv;
        wait_ready();
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_binv = binv;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("run_op", alu_op, op[1] ? op : 2'b00);
            chk("run_binv", alu_binv, eb);
            chk("run_cin", alu_cin, carry_in(op, a, b, cin, k));
            chk("run_a", alu_a, a[4*k +: 4]);
            chk("run_b", alu_b, b[4*k +: 4]);
            chk("run_rdy", cmd_ready, 1'b0);
            chk("run_vld", res_valid, 1'b0);
            @(negedge clk);
        end
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        last_lat = lat + N;
        chk("latency", 64'(last_lat), 64'(N));
        if (preload) begin
            cmd_valid = 1'b1; cmd_op = np; cmd_a = na; cmd_b = nb; cmd_cin = ncin; cmd_binv = nbinv;
        end
        for (int h = 0; h < hold; h++) begin
            chk("bp_data", res_data, er);
            chk("bp_flags", {res_cout, res_zero, res_ovf}, {ec, ez, ev});
            chk("bp_rdy", cmd_ready, 1'b0);
            chk("bp_alu", {alu_a, alu_b, alu_op, alu_cin, alu_binv}, '0);
            @(negedge clk);
        end
        chk("res_vld", res_valid, 1'b1);
        chk("res_data", res_data, er);
        chk("res_cout", res_cout, ec);
        chk("res_zero", res_zero, ez);
        chk("res_ovf", res_ovf, ev);
        last_res = res_data; last_cout = res_cout; last_zero = res_zero; last_ovf = res_ovf;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_vld", res_valid, 1'b0);
        chk("post_rdy", cmd_ready, 1'b1);
    endtask

    task automatic one(input logic [1:0] op, input logic [W-1:0] a, b,
                       input logic cin, binv, input int hold);
        do_cmd(op, a, b, cin, binv, hold, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdy", cmd_ready, 1'b0);
        chk("rst_outs", {res_valid, res_data, res_cout, res_zero, res_ovf}, '0);
        chk("rst_alu", {alu_a, alu_b, alu_op, alu_cin, alu_binv}, '0);
        rst = 1'b0;
        #1;
        chk("rel_rdy", cmd_ready, 1'b1);

        one(2'b00, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
        chk("d_add1", {last_res, last_cout, last_zero, last_ovf}, {16'h2233, 3'b000});
        one(2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        chk("d_add2", {last_res, last_cout, last_zero, last_ovf}, {16'h0000, 3'b110});
        one(2'b01, 16'h8000, 16'h0001, 1'b0, 1'b0, 0);
        chk("d_sub1", {last_res, last_cout, last_ovf}, {16'h7FFF, 2'b11});
        one(2'b01, 16'h0003, 16'h0005, 1'b0, 1'b0, 0);
        chk("d_sub2", {last_res, last_cout, last_ovf}, {16'hFFFE, 2'b00});
        one(2'b10, 16'hF0F0, 16'h3C3C, 1'b0, 1'b1, 0);
        chk("d_andn", {last_res, last_cout, last_ovf}, {16'hC0C0, 2'b00});

        // Backpressure with a pending command offered during DONE.
        do_cmd(2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 5, 1'b1,
               2'b11, 16'h1200, 16'h0034, 1'b0, 1'b0);
        chk("pend_rdy", cmd_ready, 1'b1);
        chk("pend_alu", alu_op, 2'b00);
        one(2'b11, 16'h1200, 16'h0034, 1'b0, 1'b0, 0);
        chk("d_or", last_res, 16'h1234);

        // Reset in the 2nd RUN cycle aborts the command.
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 16'h1111; cmd_b = 16'h2222; cmd_cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_vld", res_valid, 1'b0);
        chk("abort_alu", {alu_a, alu_b, alu_op, alu_cin, alu_binv}, '0);
        chk("abort_rdy", cmd_ready, 1'b0);
        @(negedge clk);
        chk("abort_rdy2", cmd_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("abort_rel", cmd_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_novld", res_valid, 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = W'($urandom);
            b  = W'($urandom);
            if (i % 8 == 0) b = ~a;
            one(op, a, b, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
